// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes IDLE -> ACCESS -> RESP, so at most one access every three cycles.
module dm_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_wr,
  input  logic [DW-1:0] dm_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          win_q, win_d;
  logic          pick;
  logic          m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_din_q, dm_din_d;
  logic          dm_wr_q, dm_wr_d;
  logic          busy_q, busy_d;

  // Next-state and registered-output logic; dm_wr_q doubles as the latched we in ACCESS.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    pick       = 1'b0;
    m0_gnt_d   = 1'b0;
    m1_gnt_d   = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    dm_addr_d  = dm_addr_q;
    dm_din_d   = dm_din_q;
    dm_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // pick=1 selects port 1; the pointer only matters on a tie
          pick  = (m0_req && m1_req) ? ptr_q : m1_req;
          win_d = pick;
          if (pick) begin
            m1_gnt_d  = 1'b1;
            dm_addr_d = m1_addr;
            dm_din_d  = m1_wdata;
            dm_wr_d   = m1_we;
          end else begin
            m0_gnt_d  = 1'b1;
            dm_addr_d = m0_addr;
            dm_din_d  = m0_wdata;
            dm_wr_d   = m0_we;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (win_q) begin
          m1_ack_d = 1'b1;
          if (!dm_wr_q) m1_rdata_d = dm_dout;
        end else begin
          m0_ack_d = 1'b1;
          if (!dm_wr_q) m0_rdata_d = dm_dout;
        end
        ptr_d   = ~win_q;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      m0_gnt_q   <= 1'b0;
      m1_gnt_q   <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      dm_addr_q  <= '0;
      dm_din_q   <= '0;
      dm_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      m0_gnt_q   <= m0_gnt_d;
      m1_gnt_q   <= m1_gnt_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      dm_addr_q  <= dm_addr_d;
      dm_din_q   <= dm_din_d;
      dm_wr_q    <= dm_wr_d;
      busy_q     <= busy_d;
    end
  end

  assign m0_gnt   = m0_gnt_q;
  assign m1_gnt   = m1_gnt_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign dm_addr  = dm_addr_q;
  assign dm_din   = dm_din_q;
  assign dm_wr    = dm_wr_q;
  assign busy     = busy_q;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning the word-address width (byte address bits [11:2]).
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous and active-high.
REQ-005 The block SHALL have ports m0_req / m1_req, input, 1, access request from requester 0 (pipeline MEM stage) / 1 (debug/DMA port).
REQ-006 The block SHALL have ports m0_we / m1_we, input, 1, write enable; 0 means read.
REQ-007 The block SHALL have ports m0_addr / m1_addr, input, AW, word address.
REQ-008 The block SHALL have ports m0_wdata / m1_wdata, input, DW, write data.
REQ-009 The block SHALL have ports m0_gnt / m1_gnt, output, 1, one-cycle pulse: request accepted, inputs latched.
REQ-010 The block SHALL have ports m0_ack / m1_ack, output, 1, one-cycle pulse: access complete; rdata valid.
REQ-011 The block SHALL have ports m0_rdata / m1_rdata, output, DW, read data, held until that port's next ack.
REQ-012 The block SHALL have ports dm_addr (output, AW), dm_din (output, DW), dm_wr (output, 1) and dm_dout (input, DW), the data-memory port; dm_dout is combinational from dm_addr.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, ACCESS and RESP, with all outputs registered.
REQ-015 In IDLE, with any req high at edge k: the block SHALL select a winner, latch its we/addr/wdata, pulse its gnt, and go to ACCESS.
REQ-016 In IDLE with no req, the block SHALL remain in IDLE with all gnt, ack and dm_wr low.
REQ-017 In ACCESS (between edges k and k+1), dm_addr/dm_din SHALL show the latched values and dm_wr SHALL equal the latched we, for exactly one cycle.
REQ-018 At edge k+1 the block SHALL capture dm_dout into the winner's rdata (reads only; on writes rdata is unchanged), pulse the winner's ack, and go to RESP.
REQ-019 At edge k+2 the block SHALL return to IDLE, and IDLE SHALL sample reqs again in that same edge's next cycle.
REQ-020 Latency: gnt SHALL appear 1 cycle after req is sampled and ack 2 cycles after; maximum throughput is one access per 3 cycles.
REQ-021 The requester SHALL drop req in the cycle its ack is high; a req still high at the next IDLE sample SHALL be treated as a new request.
REQ-022 Arbitration SHALL be round-robin: a priority pointer selects the preferred port, and after a completed access it points to the other port.
REQ-023 On simultaneous requests, the port indicated by the pointer SHALL win; a lone requester SHALL always win regardless of the pointer.
REQ-024 A req deasserted or changed after gnt SHALL be ignored; the latched transaction completes unchanged.
REQ-025 When not in ACCESS, dm_wr SHALL be 0, and dm_addr/dm_din SHALL hold their last values.
REQ-026 The gnt and ack outputs SHALL never be high for both ports in the same cycle.

Reset
REQ-027 On rst high, the block SHALL immediately (asynchronously) force state=IDLE, dm_wr=0, all gnt/ack=0, busy=0, dm_addr=0, dm_din=0, both rdata=0, and pointer=port 0.
REQ-028 A reset asserted during ACCESS SHALL abort the access, with dm_wr low before the next clock edge, and no ack SHALL be issued.
REQ-029 After rst falls, the first arbitration SHALL occur at the first rising edge with a req high.

Verification
REQ-030 A bench SHALL cover: m0 write addr 0x004 data 0xDEADBEEF -> m0_gnt at +1, dm_wr=1 with dm_addr=0x004 for one cycle, m0_ack at +2.
REQ-031 A bench SHALL cover: m1 read addr 0x004 after that write -> m1_ack at +2 with m1_rdata=0xDEADBEEF, and dm_wr stays 0 throughout.
REQ-032 A bench SHALL cover: m0 and m1 requesting simultaneously, continuously from reset -> grants in order m0, m1, m0, m1 at 3-cycle spacing.
REQ-033 A bench SHALL cover: m1 alone requesting 3 times back-to-back -> 3 grants to m1, none to m0.
REQ-034 A bench SHALL cover: rst pulsed in the ACCESS cycle of an m0 write -> dm_wr drops asynchronously, no m0_ack, busy=0, and the next request is granted normally.
REQ-035 A bench SHALL cover: m0 changing m0_addr from 0x010 to 0x020 after gnt -> the access uses 0x010.
